// File: rtl/baud_gen_multi.sv
// Fractional baud generator: phase accumulator producing oversample, bit-centre
// and bit-end strobes, with a phase restart strobe and bit-aligned rate changes.
module baud_gen_multi #(
   parameter  int ACC_W      = 24,
   parameter  int OVERSAMPLE = 16,
   localparam int PH_W       = $clog2(OVERSAMPLE)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic [ACC_W-1:0] baud_inc,
   output logic             os_tick,
   output logic             mid_tick,
   output logic             bit_tick,
   output logic [PH_W-1:0]  os_phase
);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
   localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc_r;
   logic [PH_W-1:0]  os_cnt;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic             at_last;
   logic             at_mid;

   assign sum      = {1'b0, acc} + {1'b0, inc_r};
   assign carry    = sum[ACC_W];
   assign at_last  = (os_cnt == PH_LAST);
   assign at_mid   = (os_cnt == PH_MID);
   assign os_phase = os_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         inc_r    <= '0;
         os_cnt   <= '0;
         os_tick  <= 1'b0;
         mid_tick <= 1'b0;
         bit_tick <= 1'b0;
      end else if (!en || sync) begin
         // Disabled and restart share one path: clean phase, fresh rate.
         acc      <= '0;
         inc_r    <= baud_inc;
         os_cnt   <= '0;
         os_tick  <= 1'b0;
         mid_tick <= 1'b0;
         bit_tick <= 1'b0;
      end else begin
         acc      <= sum[ACC_W-1:0];
         os_tick  <= carry;
         mid_tick <= carry && at_mid;
         bit_tick <= carry && at_last;
         if (carry)
            os_cnt <= at_last ? '0 : os_cnt + PH_ONE;
         // Rate only changes on a bit boundary so no bit is ever stretched.
         if (carry && at_last)
            inc_r <= baud_inc;
      end
   end

endmodule
